// File: rtl/ptb_acq_ctrl.sv
// Acquisition controller for one pretrigger_buffer channel: configures the
// PTB depth, detects triggers on the live front-end inputs and streams the
// framed waveform (pre-trigger + post-trigger words) into the waveform buffer.
module ptb_acq_ctrl #(
    parameter int P_DATA_WIDTH      = 22,
    parameter int P_PRE_CONF_WIDTH  = 5,
    parameter int P_POST_CONF_WIDTH = 12,
    parameter int P_ADC_WIDTH       = 12,
    parameter int P_LTC_WIDTH       = 48
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [P_ADC_WIDTH-1:0]       adc_in,
    input  logic [7:0]                   discr_in,
    input  logic                         ext_trig,
    input  logic [P_LTC_WIDTH-1:0]       ltc,
    input  logic                         arm,
    input  logic [1:0]                   trig_mode,
    input  logic [P_ADC_WIDTH-1:0]       thresh,
    input  logic [P_PRE_CONF_WIDTH-1:0]  pre_conf_req,
    input  logic [P_POST_CONF_WIDTH-1:0] post_conf,
    output logic                         ptb_rst,
    output logic [P_PRE_CONF_WIDTH-1:0]  ptb_size_config,
    input  logic                         ptb_rdy,
    input  logic [P_DATA_WIDTH-1:0]      ptb_out,
    input  logic                         wvb_full,
    output logic                         wvb_wr_en,
    output logic [P_DATA_WIDTH-1:0]      wvb_data,
    output logic                         wvb_sof,
    output logic                         wvb_eof,
    output logic [P_LTC_WIDTH-1:0]       trig_ltc,
    output logic                         trig_ltc_valid,
    output logic [15:0]                  overflow_cnt,
    output logic                         busy
);

    // Counter holds up to 2^PRE + 2^POST words without wrapping.
    localparam int CNT_W = ((P_PRE_CONF_WIDTH > P_POST_CONF_WIDTH) ?
                            P_PRE_CONF_WIDTH : P_POST_CONF_WIDTH) + 2;

    typedef enum logic [2:0] {
        S_CONFIG,
        S_WAIT_RDY,
        S_IDLE,
        S_ARMED,
        S_CAPTURE
    } state_t;

    state_t                       state_q;
    logic                         ptb_rst_q;
    logic [P_PRE_CONF_WIDTH-1:0]  size_q;
    logic [P_POST_CONF_WIDTH-1:0] post_q;
    logic [CNT_W-1:0]             cnt_q;
    logic                         wr_en_q;
    logic [P_DATA_WIDTH-1:0]      data_q;
    logic                         sof_q;
    logic                         eof_q;
    logic [P_LTC_WIDTH-1:0]       trig_ltc_q;
    logic                         tlv_q;
    logic [15:0]                  ovf_q;
    logic                         busy_q;
    logic                         trig_c_q;

    logic                         trig_c_d;
    logic                         trig_evt;
    logic                         cfg_change;
    logic [CNT_W-1:0]             last_idx;
    logic [CNT_W-1:0]             first_last;
    logic [CNT_W-1:0]             cnt_nxt;

    // Trigger condition selected by mode; mode 0 never fires.
    always_comb begin
        trig_c_d = 1'b0;
        case (trig_mode)
            2'd1:    trig_c_d = (adc_in >= thresh);
            2'd2:    trig_c_d = |discr_in;
            2'd3:    trig_c_d = ext_trig;
            default: trig_c_d = 1'b0;
        endcase
    end

    assign trig_evt   = trig_c_d & ~trig_c_q;
    assign cfg_change = (pre_conf_req != size_q);
    // Index of the final word: latched length during capture, live length at trigger.
    assign last_idx   = CNT_W'(size_q) + CNT_W'(post_q);
    assign first_last = CNT_W'(size_q) + CNT_W'(post_conf);
    assign cnt_nxt    = cnt_q + CNT_W'(1);

    // Sequencer: config/ready handshake, arming, trigger capture and framing.
    // Word 0 is emitted on the trigger edge itself so the trigger sample lands
    // at index ptb_size_config; cnt_q tracks the index currently on the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CONFIG;
            ptb_rst_q  <= 1'b1;
            size_q     <= '0;
            post_q     <= '0;
            cnt_q      <= '0;
            wr_en_q    <= 1'b0;
            data_q     <= '0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            trig_ltc_q <= '0;
            tlv_q      <= 1'b0;
            ovf_q      <= '0;
            busy_q     <= 1'b0;
            trig_c_q   <= 1'b0;
        end else begin
            trig_c_q <= trig_c_d;
            wr_en_q  <= 1'b0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            tlv_q    <= 1'b0;
            case (state_q)
                S_CONFIG: begin
                    ptb_rst_q <= 1'b0;
                    size_q    <= pre_conf_req;
                    state_q   <= S_WAIT_RDY;
                    busy_q    <= 1'b1;
                end
                S_WAIT_RDY: begin
                    if (ptb_rdy) begin
                        state_q <= arm ? S_ARMED : S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (cfg_change) begin
                        state_q   <= S_CONFIG;
                        ptb_rst_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end else if (arm) begin
                        state_q <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (cfg_change) begin
                        state_q   <= S_CONFIG;
                        ptb_rst_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end else if (!arm) begin
                        state_q <= S_IDLE;
                    end else if (trig_evt) begin
                        if (!wvb_full) begin
                            state_q    <= S_CAPTURE;
                            busy_q     <= 1'b1;
                            post_q     <= post_conf;
                            trig_ltc_q <= ltc;
                            cnt_q      <= '0;
                            wr_en_q    <= 1'b1;
                            data_q     <= ptb_out;
                            sof_q      <= 1'b1;
                            tlv_q      <= 1'b1;
                            eof_q      <= (first_last == '0);
                        end else if (ovf_q != '1) begin
                            ovf_q <= ovf_q + 16'd1;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (cnt_q == last_idx) begin
                        if (cfg_change) begin
                            state_q   <= S_CONFIG;
                            ptb_rst_q <= 1'b1;
                        end else begin
                            state_q <= arm ? S_ARMED : S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q   <= cnt_nxt;
                        wr_en_q <= 1'b1;
                        data_q  <= ptb_out;
                        eof_q   <= (cnt_nxt == last_idx);
                    end
                end
                default: begin
                    state_q   <= S_CONFIG;
                    ptb_rst_q <= 1'b1;
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

    assign ptb_rst         = ptb_rst_q;
    assign ptb_size_config = size_q;
    assign wvb_wr_en       = wr_en_q;
    assign wvb_data        = data_q;
    assign wvb_sof         = sof_q;
    assign wvb_eof         = eof_q;
    assign trig_ltc        = trig_ltc_q;
    assign trig_ltc_valid  = tlv_q;
    assign overflow_cnt    = ovf_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_ptb_acq_ctrl.sv
// Scoreboard bench for ptb_acq_ctrl with a simple PTB delay-line model.
module tb_ptb_acq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] adc_in;
    logic [7:0]  discr_in;
    logic        ext_trig;
    logic [47:0] ltc;
    logic        arm;
    logic [1:0]  trig_mode;
    logic [11:0] thresh;
    logic [4:0]  pre_conf_req;
    logic [11:0] post_conf;
    logic        ptb_rst;
    logic [4:0]  ptb_size_config;
    logic        ptb_rdy;
    logic [21:0] ptb_out;
    logic        wvb_full;
    logic        wvb_wr_en;
    logic [21:0] wvb_data;
    logic        wvb_sof;
    logic        wvb_eof;
    logic [47:0] trig_ltc;
    logic        trig_ltc_valid;
    logic [15:0] overflow_cnt;
    logic        busy;

    ptb_acq_ctrl #(
        .P_DATA_WIDTH      (22),
        .P_PRE_CONF_WIDTH  (5),
        .P_POST_CONF_WIDTH (12),
        .P_ADC_WIDTH       (12),
        .P_LTC_WIDTH       (48)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .adc_in          (adc_in),
        .discr_in        (discr_in),
        .ext_trig        (ext_trig),
        .ltc             (ltc),
        .arm             (arm),
        .trig_mode       (trig_mode),
        .thresh          (thresh),
        .pre_conf_req    (pre_conf_req),
        .post_conf       (post_conf),
        .ptb_rst         (ptb_rst),
        .ptb_size_config (ptb_size_config),
        .ptb_rdy         (ptb_rdy),
        .ptb_out         (ptb_out),
        .wvb_full        (wvb_full),
        .wvb_wr_en       (wvb_wr_en),
        .wvb_data        (wvb_data),
        .wvb_sof         (wvb_sof),
        .wvb_eof         (wvb_eof),
        .trig_ltc        (trig_ltc),
        .trig_ltc_valid  (trig_ltc_valid),
        .overflow_cnt    (overflow_cnt),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // PTB model: output is the input word delayed by ptb_size_config cycles.
    logic [21:0] cur_word;
    logic [21:0] hist [64];
    logic [1:0]  rdy_cnt;

    assign cur_word = {discr_in, adc_in, 2'b00};

    always_ff @(posedge clk) begin
        for (int i = 63; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= cur_word;
    end

    always_comb begin
        if (ptb_size_config == 5'd0) ptb_out = cur_word;
        else                         ptb_out = hist[int'(ptb_size_config) - 1];
    end

    // Ready rises a few cycles after the PTB leaves reset.
    always_ff @(posedge clk) begin
        if (ptb_rst) begin
            rdy_cnt <= 2'd0;
            ptb_rdy <= 1'b0;
        end else if (rdy_cnt < 2'd3) begin
            rdy_cnt <= rdy_cnt + 2'd1;
        end else begin
            ptb_rdy <= 1'b1;
        end
    end

    typedef struct packed {
        logic [21:0] data;
        logic        sof;
        logic        eof;
    } exp_t;

    exp_t        exp_q [$];
    logic [47:0] ltc_q [$];
    int          checks;
    int          passes;
    int          words_seen;
    int          rst_pulses;
    logic        ptb_rst_prev;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ltc = ltc + 48'd1;
    endtask

    task automatic push_word(input logic [21:0] d, input logic s, input logic e);
        exp_t x;
        x.data = d;
        x.sof  = s;
        x.eof  = e;
        exp_q.push_back(x);
    endtask

    // Monitor: pops one expectation per written word.
    task automatic monitor_loop();
        exp_t        e;
        logic [47:0] el;
        forever begin
            @(negedge clk);
            if (ptb_rst && !ptb_rst_prev) rst_pulses++;
            ptb_rst_prev = ptb_rst;
            if (wvb_wr_en) begin
                words_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_write: got data=%h sof=%b eof=%b expected no write",
                             wvb_data, wvb_sof, wvb_eof);
                end else begin
                    e = exp_q.pop_front();
                    if ({wvb_data, wvb_sof, wvb_eof, trig_ltc_valid} === {e.data, e.sof, e.eof, e.sof})
                        passes++;
                    else
                        $display("FAIL word: got data=%h sof=%b eof=%b tlv=%b expected data=%h sof=%b eof=%b",
                                 wvb_data, wvb_sof, wvb_eof, trig_ltc_valid, e.data, e.sof, e.eof);
                    if (e.sof) begin
                        el = (ltc_q.size() != 0) ? ltc_q.pop_front() : '1;
                        chk("trig_ltc", 64'(trig_ltc), 64'(el));
                    end
                end
            end
        end
    endtask

    task automatic wait_busy_low(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk("busy_low", 64'(busy), 64'd0);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        repeat (4) step();
    endtask

    // Ramp the ADC; the crossing value 100 is the trigger sample, so word k
    // carries adc value 100 - pre + k.
    task automatic ramp_capture(input int unsigned lo, input int unsigned hi,
                                input int unsigned pre, input int unsigned post,
                                input int unsigned chg_at);
        for (int unsigned v = lo; v <= hi; v++) begin
            step();
            adc_in = 12'(v);
            if (v == 100) begin
                for (int unsigned k = 0; k <= pre + post; k++)
                    push_word({8'h00, 12'(100 - pre + k), 2'b00}, k == 0, k == pre + post);
                ltc_q.push_back(ltc);
            end
            if (chg_at != 0 && v == chg_at) pre_conf_req = 5'd16;
        end
    endtask

    // Discriminator waveform with pre=16, post=10: discr is 0 before the trigger.
    task automatic push_discr_wave();
        for (int unsigned k = 0; k <= 26; k++)
            push_word({(k >= 16) ? 8'h5A : 8'h00, 12'h123, 2'b00}, k == 0, k == 26);
        ltc_q.push_back(ltc);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int w0;
        int p0;
        checks = 0; passes = 0; words_seen = 0; rst_pulses = 0; ptb_rst_prev = 1'b1;
        rst = 1'b1; adc_in = '0; discr_in = '0; ext_trig = 1'b0; ltc = '0;
        arm = 1'b1; trig_mode = 2'd0; thresh = '0; pre_conf_req = 5'd4;
        post_conf = 12'd10; wvb_full = 1'b0;
        fork
            monitor_loop();
        join_none

        // Reset and initial configuration
        repeat (4) step();
        @(negedge clk);
        chk("rst_ptb_rst", 64'(ptb_rst), 64'd1);
        chk("rst_wr_en", 64'(wvb_wr_en), 64'd0);
        chk("rst_size", 64'(ptb_size_config), 64'd0);
        chk("rst_ovf", 64'(overflow_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tlv", 64'(trig_ltc_valid), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("cfg_ptb_rst_hold", 64'(ptb_rst), 64'd1);
        step();
        @(negedge clk);
        chk("cfg_ptb_rst_low", 64'(ptb_rst), 64'd0);
        chk("cfg_size", 64'(ptb_size_config), 64'd4);
        chk("cfg_busy", 64'(busy), 64'd1);
        wait_busy_low(30);

        // Threshold trigger, pre=4 post=10
        trig_mode = 2'd1;
        thresh = 12'd100;
        w0 = words_seen;
        ramp_capture(50, 130, 4, 10, 0);
        adc_in = '0;
        wait_drain(40);
        chk("t1_words", 64'(words_seen - w0), 64'd15);

        // Depth change mid-capture is deferred to after EOF
        w0 = words_seen;
        p0 = rst_pulses;
        ramp_capture(80, 130, 4, 10, 105);
        adc_in = '0;
        wait_drain(40);
        wait_busy_low(30);
        chk("t2_words", 64'(words_seen - w0), 64'd15);
        chk("t2_rst_pulses", 64'(rst_pulses - p0), 64'd1);
        chk("t2_size", 64'(ptb_size_config), 64'd16);

        w0 = words_seen;
        ramp_capture(80, 140, 16, 10, 0);
        adc_in = '0;
        wait_drain(60);
        chk("t3_words", 64'(words_seen - w0), 64'd27);

        // Overflow: triggers while the waveform buffer is full
        trig_mode = 2'd3;
        wvb_full = 1'b1;
        w0 = words_seen;
        repeat (3) begin
            step(); ext_trig = 1'b1;
            step();
            step(); ext_trig = 1'b0;
            step();
        end
        repeat (3) step();
        chk("t4_ovf", 64'(overflow_cnt), 64'd3);
        chk("t4_words", 64'(words_seen - w0), 64'd0);
        wvb_full = 1'b0;

        // Long discriminator pulse fires once; post_conf change mid-capture ignored
        trig_mode = 2'd2;
        adc_in = 12'h123;
        repeat (20) step();
        w0 = words_seen;
        step(); discr_in = 8'h5A;
        push_discr_wave();
        for (int i = 1; i < 40; i++) begin
            step();
            if (i == 5)  post_conf = 12'd3;
            if (i == 30) post_conf = 12'd10;
        end
        step(); discr_in = 8'h00;
        repeat (19) step();
        step(); discr_in = 8'h5A;
        push_discr_wave();
        repeat (5) step();
        arm = 1'b0;
        wait_drain(60);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_words", 64'(words_seen - w0), 64'd54);
        discr_in = 8'h00;
        repeat (3) step();
        discr_in = 8'h5A;
        repeat (4) step();
        chk("t5_idle_words", 64'(words_seen - w0), 64'd54);
        chk("t5_idle_ovf", 64'(overflow_cnt), 64'd3);
        discr_in = 8'h00;
        arm = 1'b1;
        repeat (3) step();

        // One-word waveform: depth 0, post 0
        pre_conf_req = 5'd0;
        post_conf = 12'd0;
        trig_mode = 2'd3;
        repeat (2) step();
        wait_busy_low(30);
        chk("t6_size", 64'(ptb_size_config), 64'd0);
        w0 = words_seen;
        step(); ext_trig = 1'b1;
        push_word({8'h00, 12'h123, 2'b00}, 1'b1, 1'b1);
        ltc_q.push_back(ltc);
        step();
        step(); ext_trig = 1'b0;
        wait_drain(10);
        chk("t6_words", 64'(words_seen - w0), 64'd1);

        // Reset while word 5 of an 11-word capture is on the output
        post_conf = 12'd10;
        w0 = words_seen;
        step(); ext_trig = 1'b1;
        for (int unsigned k = 0; k <= 10; k++)
            push_word({8'h00, 12'h123, 2'b00}, k == 0, k == 10);
        ltc_q.push_back(ltc);
        repeat (6) step();
        rst = 1'b1;
        ext_trig = 1'b0;
        step();
        @(negedge clk);
        chk("t7_wr_en", 64'(wvb_wr_en), 64'd0);
        chk("t7_eof", 64'(wvb_eof), 64'd0);
        chk("t7_ptb_rst", 64'(ptb_rst), 64'd1);
        chk("t7_words", 64'(words_seen - w0), 64'd6);
        chk("t7_remaining", 64'(exp_q.size()), 64'd5);
        exp_q.delete();
        ltc_q.delete();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t7_cfg_ptb_rst", 64'(ptb_rst), 64'd1);
        step();
        @(negedge clk);
        chk("t7_wait_ptb_rst", 64'(ptb_rst), 64'd0);
        chk("t7_wait_busy", 64'(busy), 64'd1);
        wait_busy_low(30);
        repeat (3) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
